uart_xcvr: RTL and testbench

UART_XCVR -- requirements
Module: uart_xcvr

---
 rtl/uart_xcvr.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: 16x-oversampled RX with start-glitch rejection and internal loopback.
// Define UART_XCVR_PARITY_EN to add an even-parity bit to every frame (TX inserts, RX checks).
module uart_xcvr #(
    parameter int CLKS_PER_TICK = 4,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loopback_en,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data_in,
    output logic                 tx_serial_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_serial_in,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int BIT_CLKS = 16 * CLKS_PER_TICK;
    localparam int CNT_W    = $clog2(BIT_CLKS);
    localparam int PRE_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_XCVR_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_bit_end;
    logic                   tx_line;
`ifdef UART_XCVR_PARITY_EN
    logic                   tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done_d  = 1'b0;
        tx_bit_end = (tx_cnt_q == CNT_LAST);
`ifdef UART_XCVR_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q == ST_IDLE) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (tx_start) begin
                tx_state_d = ST_START;
                tx_shift_d = tx_data_in;
`ifdef UART_XCVR_PARITY_EN
                tx_par_d   = ^tx_data_in;
`endif
            end
        end else if (tx_bit_end) begin
            tx_cnt_d = '0;
            case (tx_state_q)
                ST_START: begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                end
                ST_DATA: begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_XCVR_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                ST_PARITY: begin
                    tx_state_d = ST_STOP;
                    tx_bit_d   = '0;
                end
`endif
                ST_STOP: begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = ST_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
                default: tx_state_d = ST_IDLE;
            endcase
        end else begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
    end

    // Line level follows the registered state, so it changes exactly on bit boundaries.
    always_comb begin
        case (tx_state_q)
            ST_START:  tx_line = 1'b0;
            ST_DATA:   tx_line = tx_shift_q[0];
`ifdef UART_XCVR_PARITY_EN
            ST_PARITY: tx_line = tx_par_q;
`endif
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_done_q  <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_XCVR_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx_serial_out = loopback_en ? 1'b1 : tx_line;
    assign tx_busy       = (tx_state_q != ST_IDLE);
    assign tx_done       = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]             sync_q;
    logic                   rx_line;
    state_t                 rx_state_q, rx_state_d;
    logic [PRE_W-1:0]       rx_pre_q, rx_pre_d;
    logic [3:0]             rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_armed_q, rx_armed_d;
    logic                   rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_tick_end, rx_sample, rx_bit_end;
`ifdef UART_XCVR_PARITY_EN
    logic                   rx_parbit_q, rx_parbit_d;
    logic                   rx_perr_q, rx_perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_serial_in};
        end
    end

    // Loopback taps the raw TX line, which is already in this clock domain.
    assign rx_line = loopback_en ? tx_line : sync_q[1];

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_pre_d    = rx_pre_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_armed_d  = rx_armed_q;
        rx_done_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_ferr_d   = rx_ferr_q;
        rx_tick_end = (rx_pre_q == PRE_LAST);
        rx_sample   = rx_tick_end && (rx_tick_q == 4'd7);
        rx_bit_end  = rx_tick_end && (rx_tick_q == 4'd15);
`ifdef UART_XCVR_PARITY_EN
        rx_parbit_d = rx_parbit_q;
        rx_perr_d   = rx_perr_q;
`endif
        if (rx_state_q == ST_IDLE) begin
            rx_pre_d  = '0;
            rx_tick_d = '0;
            rx_bit_d  = '0;
            // After a frame error the line must return high before a new start counts.
            if (!rx_armed_q) begin
                rx_armed_d = rx_line;
            end else if (!rx_line) begin
                rx_state_d = ST_START;
            end
        end else begin
            rx_pre_d = rx_tick_end ? '0 : rx_pre_q + PRE_W'(1);
            if (rx_tick_end) begin
                rx_tick_d = rx_tick_q + 4'd1;
            end
            case (rx_state_q)
                ST_START: begin
                    if (rx_sample && rx_line) begin
                        rx_state_d = ST_IDLE;
                    end else if (rx_bit_end) begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (rx_sample) begin
                        rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                    end
                    if (rx_bit_end) begin
                        if (rx_bit_q == DATA_LAST) begin
`ifdef UART_XCVR_PARITY_EN
                            rx_state_d = ST_PARITY;
`else
                            rx_state_d = ST_STOP;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                ST_PARITY: begin
                    if (rx_sample) begin
                        rx_parbit_d = rx_line;
                    end
                    if (rx_bit_end) begin
                        rx_state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_sample) begin
                        rx_state_d = ST_IDLE;
                        rx_done_d  = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_ferr_d  = ~rx_line;
                        rx_armed_d = rx_line;
`ifdef UART_XCVR_PARITY_EN
                        rx_perr_d  = (^rx_shift_q) ^ rx_parbit_q;
`endif
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= ST_IDLE;
            rx_pre_q    <= '0;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_armed_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_ferr_q   <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            rx_parbit_q <= 1'b0;
            rx_perr_q   <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            rx_pre_q    <= rx_pre_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_armed_q  <= rx_armed_d;
            rx_done_q   <= rx_done_d;
            rx_data_q   <= rx_data_d;
            rx_ferr_q   <= rx_ferr_d;
`ifdef UART_XCVR_PARITY_EN
            rx_parbit_q <= rx_parbit_d;
            rx_perr_q   <= rx_perr_d;
`endif
        end
    end

    assign rx_done      = rx_done_q;
    assign rx_data_out  = rx_data_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_XCVR_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: a frame-injection vector table plus hand-written TX/loopback/reset sequences.
module tb_uart_xcvr;

`ifdef UART_XCVR_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam bit PAR_ON   = 1'b1;
`else
    localparam int PAR_BITS = 0;
    localparam bit PAR_ON   = 1'b0;
`endif
    localparam int BIT_CLKS = 64;
    localparam int LEN8     = (1 + 8 + PAR_BITS + 1) * BIT_CLKS + 1;
    localparam int LEN5     = (1 + 5 + PAR_BITS + 2) * BIT_CLKS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       loopback_en = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       tx_serial_out, tx_busy, tx_done;
    logic       rx_drv = 1'b1;
    logic       rx_sel = 1'b0;
    logic       rx_line;
    logic       rx_done, rx_frame_err, rx_parity_err;
    logic [7:0] rx_data_out;

    logic       lb5 = 1'b0;
    logic       tx5_start = 1'b0;
    logic [4:0] tx5_data = 5'h00;
    logic       tx5_serial_out, tx5_busy, tx5_done;
    logic       rx5_done, rx5_ferr, rx5_perr;
    logic [4:0] rx5_data;

    always #5 clk = ~clk;

    assign rx_line = rx_sel ? tx_serial_out : rx_drv;

    uart_xcvr u_dut (
        .clk(clk), .rst(rst), .loopback_en(loopback_en),
        .tx_start(tx_start), .tx_data_in(tx_data_in),
        .tx_serial_out(tx_serial_out), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_serial_in(rx_line), .rx_done(rx_done), .rx_data_out(rx_data_out),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    uart_xcvr #(.CLKS_PER_TICK(4), .DATA_BITS(5), .STOP_BITS(2)) u_dut5 (
        .clk(clk), .rst(rst), .loopback_en(lb5),
        .tx_start(tx5_start), .tx_data_in(tx5_data),
        .tx_serial_out(tx5_serial_out), .tx_busy(tx5_busy), .tx_done(tx5_done),
        .rx_serial_in(tx5_serial_out), .rx_done(rx5_done), .rx_data_out(rx5_data),
        .rx_frame_err(rx5_ferr), .rx_parity_err(rx5_perr)
    );

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         rx_cnt   = 0;
    int         txd_cnt  = 0;
    int         lb_low   = 0;
    int         rx5_cnt  = 0;
    int         tx5d_cnt = 0;
    logic [7:0] rx_log   [64];
    bit         ferr_log [64];
    bit         perr_log [64];
    logic [4:0] rx5_last = 5'h00;

    always @(negedge clk) begin
        if (rx_done) begin
            rx_log[rx_cnt % 64]   = rx_data_out;
            ferr_log[rx_cnt % 64] = rx_frame_err;
            perr_log[rx_cnt % 64] = rx_parity_err;
            rx_cnt++;
        end
        if (tx_done) txd_cnt++;
        if (loopback_en && tx_serial_out !== 1'b1) lb_low++;
        if (rx5_done) begin
            rx5_last = rx5_data;
            rx5_cnt++;
        end
        if (tx5_done) tx5d_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         stop_v;
        bit         pflip;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_tx(input bit five, input logic [7:0] d);
        if (five) begin
            tx5_data  = d[4:0];
            tx5_start = 1'b1;
        end else begin
            tx_data_in = d;
            tx_start   = 1'b1;
        end
        cyc(1);
        tx_start  = 1'b0;
        tx5_start = 1'b0;
    endtask

    // k counts cycles since acceptance; returns in the tx_done cycle.
    task automatic wait_done(input bit five, output int k);
        k = 1;
        while (!(five ? tx5_done : tx_done) && k < 3000) begin
            cyc(1);
            k++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit pflip);
        rx_drv = 1'b0;
        cyc(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cyc(BIT_CLKS);
        end
        if (PAR_BITS == 1) begin
            rx_drv = (^d) ^ pflip;
            cyc(BIT_CLKS);
        end
        rx_drv = stop_v;
        cyc(BIT_CLKS);
        rx_drv = 1'b1;
        cyc(2 * BIT_CLKS);
    endtask

    initial begin
        int k;
        int base;
        int tbase;

        vecs[0] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, PAR_ON};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hA6, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0};

        // Reset state
        cyc(3);
        chk("rst_tx_line", tx_serial_out, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_rx_done", rx_done, 0);
        chk("rst_rx_data", rx_data_out, 0);
        chk("rst_rx_ferr", rx_frame_err, 0);
        chk("rst_rx_perr", rx_parity_err, 0);
        rst = 1'b0;
        cyc(10);

        // Internal loopback
        loopback_en = 1'b1;
        base = rx_cnt;
        start_tx(1'b0, 8'h37);
        chk("lb_busy", tx_busy, 1);
        chk("lb_line_high", tx_serial_out, 1);
        wait_done(1'b0, k);
        chk("lb_len", k, LEN8);
        cyc(20);
        chk("lb_rx_cnt", rx_cnt, base + 1);
        chk("lb_data", rx_log[base % 64], 8'h37);
        chk("lb_ferr", ferr_log[base % 64], 0);
        chk("lb_perr", perr_log[base % 64], 0);
        chk("lb_line_low_cycles", lb_low, 0);
        $display("loopback frame 0x37: rx_cnt=%0d data=0x%0h", rx_cnt - base, rx_log[base % 64]);
        loopback_en = 1'b0;
        cyc(10);

        // Start-bit glitch
        base = rx_cnt;
        rx_drv = 1'b0;
        cyc(20);
        rx_drv = 1'b1;
        cyc(200);
        chk("glitch_no_rx", rx_cnt, base);
        $display("glitch 20 clk: rx_done pulses=%0d", rx_cnt - base);

        // Injected frames
        for (int i = 0; i < 7; i++) begin
            base = rx_cnt;
            send_frame(vecs[i].data, vecs[i].stop_v, vecs[i].pflip);
            chk($sformatf("vec%0d_cnt", i), rx_cnt, base + 1);
            chk($sformatf("vec%0d_data", i), rx_log[base % 64], vecs[i].exp_data);
            chk($sformatf("vec%0d_ferr", i), ferr_log[base % 64], vecs[i].exp_ferr);
            chk($sformatf("vec%0d_perr", i), perr_log[base % 64], vecs[i].exp_perr);
            $display("vec%0d sent=0x%0h stop=%0b pflip=%0b -> data=0x%0h ferr=%0b perr=%0b",
                     i, vecs[i].data, vecs[i].stop_v, vecs[i].pflip,
                     rx_log[base % 64], ferr_log[base % 64], perr_log[base % 64]);
        end

        // Back-to-back over the external wire
        rx_sel = 1'b1;
        cyc(10);
        base = rx_cnt;
        start_tx(1'b0, 8'hA5);
        wait_done(1'b0, k);
        chk("b2b_len1", k, LEN8);
        start_tx(1'b0, 8'h5A);
        chk("b2b_no_gap", tx_serial_out, 0);
        chk("b2b_busy", tx_busy, 1);
        wait_done(1'b0, k);
        chk("b2b_len2", k, LEN8);
        cyc(20);
        chk("b2b_rx_cnt", rx_cnt, base + 2);
        chk("b2b_data1", rx_log[base % 64], 8'hA5);
        chk("b2b_data2", rx_log[(base + 1) % 64], 8'h5A);
        chk("b2b_ferr2", ferr_log[(base + 1) % 64], 0);
        $display("back-to-back: 0x%0h then 0x%0h", rx_log[base % 64], rx_log[(base + 1) % 64]);

        // Reset during data bit 4, 8-bit instance
        base  = rx_cnt;
        tbase = txd_cnt;
        start_tx(1'b0, 8'hC3);
        cyc(5 * BIT_CLKS + 10);
        chk("abort_busy_before", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_line", tx_serial_out, 1);
        chk("abort_busy", tx_busy, 0);
        cyc(3);
        rst = 1'b0;
        cyc(900);
        chk("abort_no_tx_done", txd_cnt, tbase);
        chk("abort_no_rx_done", rx_cnt, base);
        start_tx(1'b0, 8'hFF);
        wait_done(1'b0, k);
        chk("recover_len", k, LEN8);
        cyc(20);
        chk("recover_rx_cnt", rx_cnt, base + 1);
        chk("recover_data", rx_log[base % 64], 8'hFF);
        $display("abort + recover 8-bit: data=0x%0h", rx_log[base % 64]);

        // 5 data bits, 2 stop bits
        base = rx5_cnt;
        start_tx(1'b1, 8'h15);
        wait_done(1'b1, k);
        chk("d5_len", k, LEN5);
        cyc(100);
        chk("d5_rx_cnt", rx5_cnt, base + 1);
        chk("d5_data", rx5_last, 5'h15);
        $display("5-bit frame 0x15: len=%0d data=0x%0h", k, rx5_last);

        base  = rx5_cnt;
        tbase = tx5d_cnt;
        start_tx(1'b1, 8'h0A);
        cyc(5 * BIT_CLKS + 10);
        chk("d5_abort_busy_before", tx5_busy, 1);
        rst = 1'b1;
        #1;
        chk("d5_abort_line", tx5_serial_out, 1);
        chk("d5_abort_busy", tx5_busy, 0);
        cyc(3);
        rst = 1'b0;
        cyc(700);
        chk("d5_abort_no_tx_done", tx5d_cnt, tbase);
        chk("d5_abort_no_rx_done", rx5_cnt, base);
        start_tx(1'b1, 8'h1F);
        wait_done(1'b1, k);
        chk("d5_recover_len", k, LEN5);
        cyc(100);
        chk("d5_recover_cnt", rx5_cnt, base + 1);
        chk("d5_recover_data", rx5_last, 5'h1F);
        chk("d5_recover_ferr", rx5_ferr, 0);
        $display("abort + recover 5-bit: len=%0d data=0x%0h", k, rx5_last);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
